fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode control unit.
- Owns PC_F and issues requests to instruction memory over a req/ready + rvalid handshake.
- Buffers returned instructions in a 2-entry FIFO so decode stalls never drop data.
- Presents the IF/ID register contents (instr, PC, PC+4, valid, opcode) to decode; the opcode is consumed directly by the control unit.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC_F value after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- o_imem_req  out  1  fetch request valid.
- o_imem_addr  out  XLEN  fetch address (= PC_F).
- i_imem_ready  in  1  memory accepts request this cycle.
- i_imem_rvalid  in  1  response valid.
- i_imem_rdata  in  32  response instruction.
- i_stall_d  in  1  hold IF/ID register.
- i_flush_d  in  1  load bubble into IF/ID.
- i_pc_src_e  in  1  redirect (taken branch/jump) from EX.
- i_pc_target_e  in  XLEN  redirect target.
- o_instr_d  out  32  IF/ID instruction.
- o_opcode_d  out  7  o_instr_d[6:0], to control unit.
- o_pc_d  out  XLEN  PC of o_instr_d.
- o_pc_plus4_d  out  XLEN  o_pc_d + 4.
- o_valid_d  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (sync, i_rst high at edge):
  - PC_F=RESET_PC; FIFO empty; outstanding=0; epoch=0.
  - o_instr_d=NOP_INSTR, o_opcode_d=7'h13, o_pc_d=0, o_pc_plus4_d=0, o_valid_d=0.
  - o_imem_req=0 while i_rst high.
  - The instruction memory shares i_rst; no responses arrive after reset.
  - Reset mid-operation discards FIFO, outstanding request and IF/ID contents.
- At most one request outstanding. Each request tags {PC, epoch}; tag is held in a register.
- o_imem_req = !i_rst && !i_pc_src_e && (!outstanding || i_imem_rvalid) && (fifo_count + outstanding) < 2.
  - The rvalid→req path is combinational; it sustains 1 fetch/cycle with a 1-cycle memory.
- Accept (req && ready):
  - outstanding<=1; tag<={PC_F, epoch}; PC_F<=PC_F+4 (mod 2^XLEN, wrap silently).
- Response (rvalid):
  - outstanding<=0 unless a new accept happens in the same cycle.
  - Response is kept iff tag epoch==epoch and i_pc_src_e==0; otherwise it is dropped.
- Redirect (i_pc_src_e):
  - PC_F<=i_pc_target_e with bits [1:0] forced to 0.
  - FIFO cleared; epoch toggles.
  - No request issued that cycle.
  - A still-outstanding old request is dropped on return.
  - IF/ID is NOT touched by redirect; the hazard unit asserts i_flush_d with it.
- FIFO: 2 entries of {instr, pc}.
  - Push = kept response not bypassed. Pop = IF/ID load from head.
  - Push and pop in the same cycle are allowed.
  - Overflow is impossible by construction of the req condition; the bench asserts it.
- IF/ID update each edge, in priority order:
  1. i_rst → reset values.
  2. i_flush_d → bubble (NOP_INSTR, valid=0, pc fields 0). Flush beats stall. A kept response this cycle is pushed, not lost.
  3. i_stall_d → hold all outputs; no pop.
  4. FIFO non-empty → load head (valid=1), pop. A kept response the same cycle is pushed.
  5. FIFO empty and kept response → bypass: load {rdata, tag PC}, valid=1.
  6. Otherwise → bubble.
- Latency: request accepted cycle N, rvalid cycle N+1 → instruction on o_instr_d after the N+1 edge (bypass), FIFO empty, no stall.
- o_pc_plus4_d is computed at load time from the loaded pc; a bubble gives 0.
- o_opcode_d always equals o_instr_d[6:0].

Test Plan:
- Reset, 1-cycle memory always ready, stream addi at 0x0,0x4,0x8 → o_pc_d=0,4,8 on consecutive cycles; o_valid_d=1; o_opcode_d=7'h13 each; first valid 2 cycles after reset release.
- i_stall_d high 3 cycles during stream → o_instr_d/o_pc_d held; FIFO fills to 2, o_imem_req drops; on release PCs continue in order, none skipped or duplicated.
- Redirect to 0x103 while a request to 0x10 is outstanding → response for 0x10 dropped; next o_pc_d=0x100; FIFO entries discarded.
- i_flush_d and i_stall_d together → bubble (o_valid_d=0, o_instr_d=0x13); a same-cycle response is delivered the next unstalled cycle.
- i_imem_ready low 4 cycles, then rvalid delayed 3 cycles → single outstanding request, o_imem_addr stable while req&&!ready, PC_F advances only on accept.
- Assert i_rst mid-stream with FIFO holding 2 entries → next cycle all outputs at reset values, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register. At most one imem request is in flight.
// A 2-entry FIFO holds returned instructions while decode stalls.
module fetch_stage #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ready,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    input  logic            i_stall_d,
    input  logic            i_flush_d,
    input  logic            i_pc_src_e,
    input  logic [XLEN-1:0] i_pc_target_e,
    output logic [31:0]     o_instr_d,
    output logic [6:0]      o_opcode_d,
    output logic [XLEN-1:0] o_pc_d,
    output logic [XLEN-1:0] o_pc_plus4_d,
    output logic            o_valid_d
);
    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] pcf_q, pcf_d, tag_pc_q, tag_pc_d;
    logic            epoch_q, epoch_d, tag_epoch_q, tag_epoch_d, out_q, out_d;
    entry_t          fifo_q [2];
    entry_t          fifo_d [2];
    logic            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d, pc4_q, pc4_d;
    logic            valid_q, valid_d;
    logic            accept, kept, advance, load_head, bypass, push;
    entry_t          head;

    // rvalid feeds req combinationally so a 1-cycle memory sustains one fetch per cycle
    assign o_imem_req  = !i_rst && !i_pc_src_e && (!out_q || i_imem_rvalid)
                         && (({1'b0, cnt_q} + {2'b0, out_q}) < 3'd2);
    assign o_imem_addr = pcf_q;
    assign accept      = o_imem_req && i_imem_ready;
    // stale-epoch responses belong to a path abandoned by an earlier redirect
    assign kept        = i_imem_rvalid && out_q && (tag_epoch_q == epoch_q) && !i_pc_src_e;
    assign advance     = !i_flush_d && !i_stall_d;
    assign load_head   = advance && (cnt_q != 2'd0);
    assign bypass      = advance && (cnt_q == 2'd0) && kept;
    assign push        = kept && !bypass;
    assign head        = fifo_q[rd_ptr_q];

    always_comb begin
        pcf_d       = pcf_q;
        epoch_d     = epoch_q;
        out_d       = out_q;
        tag_pc_d    = tag_pc_q;
        tag_epoch_d = tag_epoch_q;
        fifo_d      = fifo_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q + {1'b0, push} - {1'b0, load_head};
        instr_d     = instr_q;
        pc_d        = pc_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;

        if (i_imem_rvalid) out_d = 1'b0;
        if (accept) begin
            out_d       = 1'b1;
            tag_pc_d    = pcf_q;
            tag_epoch_d = epoch_q;
            pcf_d       = pcf_q + XLEN'(4);
        end
        if (push) begin
            fifo_d[wr_ptr_q] = '{instr: i_imem_rdata, pc: tag_pc_q};
            wr_ptr_d         = !wr_ptr_q;
        end
        if (load_head) rd_ptr_d = !rd_ptr_q;
        if (i_pc_src_e) begin
            pcf_d    = {i_pc_target_e[XLEN-1:2], 2'b00};
            epoch_d  = !epoch_q;
            cnt_d    = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end

        if (i_flush_d || (advance && !load_head && !bypass)) begin
            instr_d = NOP_INSTR;
            pc_d    = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (load_head) begin
            instr_d = head.instr;
            pc_d    = head.pc;
            pc4_d   = head.pc + XLEN'(4);
            valid_d = 1'b1;
        end else if (bypass) begin
            instr_d = i_imem_rdata;
            pc_d    = tag_pc_q;
            pc4_d   = tag_pc_q + XLEN'(4);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pcf_q       <= RESET_PC;
            epoch_q     <= 1'b0;
            out_q       <= 1'b0;
            tag_pc_q    <= '0;
            tag_epoch_q <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            instr_q     <= NOP_INSTR;
            pc_q        <= '0;
            pc4_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            pcf_q       <= pcf_d;
            epoch_q     <= epoch_d;
            out_q       <= out_d;
            tag_pc_q    <= tag_pc_d;
            tag_epoch_q <= tag_epoch_d;
            fifo_q      <= fifo_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
        end
    end

    assign o_instr_d    = instr_q;
    assign o_opcode_d   = instr_q[6:0];
    assign o_pc_d       = pc_q;
    assign o_pc_plus4_d = pc4_q;
    assign o_valid_d    = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural imem with variable latency, in-order PC scoreboard.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0, i_rst = 1'b1;
    logic        o_imem_req, i_imem_ready = 1'b1, i_imem_rvalid = 1'b0;
    logic [31:0] o_imem_addr, i_imem_rdata = '0;
    logic        i_stall_d = 1'b0, i_flush_d = 1'b0, i_pc_src_e = 1'b0;
    logic [31:0] i_pc_target_e = '0;
    logic [31:0] o_instr_d, o_pc_d, o_pc_plus4_d;
    logic [6:0]  o_opcode_d;
    logic        o_valid_d;

    fetch_stage dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ready(i_imem_ready), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .i_stall_d(i_stall_d), .i_flush_d(i_flush_d),
        .i_pc_src_e(i_pc_src_e), .i_pc_target_e(i_pc_target_e),
        .o_instr_d(o_instr_d), .o_opcode_d(o_opcode_d), .o_pc_d(o_pc_d),
        .o_pc_plus4_d(o_pc_plus4_d), .o_valid_d(o_valid_d)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch = '0, mem_addr = '0, last_pc = '0;
    logic        mem_busy = 1'b0, last_valid = 1'b0, s_req = 1'b0, delivered = 1'b0;
    logic        acc = 1'b0;
    logic [31:0] acc_addr = '0;
    int          mem_wait = 0, lat = 1, ndeliv = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [31:0] a);
        return {a[24:0], 7'h13};
    endfunction

    task automatic reset_sb(input logic [31:0] base);
        exp_q.delete();
        for (int k = 0; k < 64; k++) exp_q.push_back(base + 32'(4 * k));
    endtask

    // one clock: drive memory at negedge, sample req, clock edge, then check IF/ID
    task automatic step();
        logic p_rst, p_stall, p_flush, p_src, rv;
        rv            = mem_busy && (mem_wait == 1) && !i_rst;
        i_imem_rvalid = rv;
        i_imem_rdata  = rv ? ins(mem_addr) : 32'hDEAD_BEEF;
        #1;
        s_req = o_imem_req;
        if (i_rst) chk("req_in_rst", 64'(s_req), 64'd0);
        if (i_pc_src_e) chk("req_on_redir", 64'(s_req), 64'd0);
        if (s_req) chk("fetch_addr", 64'(o_imem_addr), 64'(exp_fetch));
        p_rst = i_rst; p_stall = i_stall_d; p_flush = i_flush_d; p_src = i_pc_src_e;
        acc = s_req && i_imem_ready && !i_rst;
        @(posedge i_clk);
        if (p_rst) begin
            mem_busy  = 1'b0;
            exp_fetch = '0;
        end else begin
            if (acc) chk("one_outstanding", 64'(mem_busy && !rv), 64'd0);
            if (rv) mem_busy = 1'b0;
            else if (mem_busy) mem_wait--;
            if (acc) begin
                mem_busy = 1'b1; mem_wait = lat; mem_addr = exp_fetch;
                acc_addr = exp_fetch; exp_fetch += 4;
            end
            if (p_src) exp_fetch = i_pc_target_e & ~32'h3;
        end
        #1;
        delivered = 1'b0;
        chk("fifo_bound", 64'(dut.cnt_q > 2'd2), 64'd0);
        if (p_rst || p_flush) begin
            chk(p_rst ? "rst_valid" : "flush_valid", 64'(o_valid_d), 64'd0);
            chk(p_rst ? "rst_instr" : "flush_instr", 64'(o_instr_d), 64'(NOP));
            chk(p_rst ? "rst_opcode" : "flush_opcode", 64'(o_opcode_d), 64'h13);
            chk(p_rst ? "rst_pc" : "flush_pc", 64'(o_pc_d), 64'd0);
            chk(p_rst ? "rst_pc4" : "flush_pc4", 64'(o_pc_plus4_d), 64'd0);
            last_valid = 1'b0; last_pc = '0;
        end else if (p_stall) begin
            chk("stall_valid", 64'(o_valid_d), 64'(last_valid));
            chk("stall_pc", 64'(o_pc_d), 64'(last_pc));
        end else if (o_valid_d) begin
            if (exp_q.size() == 0) chk("sb_empty", 64'(o_pc_d), 64'hFFFF_FFFF);
            else begin
                last_pc = exp_q.pop_front();
                chk("pc", 64'(o_pc_d), 64'(last_pc));
                chk("instr", 64'(o_instr_d), 64'(ins(last_pc)));
                chk("opcode", 64'(o_opcode_d), 64'(ins(last_pc) & 32'h7f));
                chk("pc4", 64'(o_pc_plus4_d), 64'(last_pc + 32'd4));
            end
            last_valid = 1'b1; delivered = 1'b1; ndeliv++;
        end else begin
            chk("bubble_instr", 64'(o_instr_d), 64'(NOP));
            last_valid = 1'b0; last_pc = '0;
        end
        @(negedge i_clk);
    endtask

    initial begin
        int  first;
        logic found;
        reset_sb(32'h0);
        @(negedge i_clk);
        step(); step();
        // stream from reset with a 1-cycle memory
        i_rst = 1'b0; first = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (delivered && first < 0) first = i;
        end
        chk("first_valid_cycle", 64'(first), 64'd2);
        chk("stream_count", 64'(ndeliv), 64'd7);
        // decode stall fills FIFO and throttles fetch
        i_stall_d = 1'b1;
        step(); step(); step();
        chk("req_drop_full", 64'(s_req), 64'd0);
        i_stall_d = 1'b0;
        for (int i = 0; i < 6; i++) step();
        // flush and stall together
        i_flush_d = 1'b1; i_stall_d = 1'b1;
        step();
        i_flush_d = 1'b0; i_stall_d = 1'b0;
        for (int i = 0; i < 5; i++) step();
        // redirect while the request for 0x10 is outstanding
        i_rst = 1'b1; reset_sb(32'h0); step(); i_rst = 1'b0;
        lat = 3; found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (acc && acc_addr == 32'h10) found = 1'b1;
        end
        chk("reach_0x10", 64'(found), 64'd1);
        i_pc_src_e = 1'b1; i_pc_target_e = 32'h103; i_flush_d = 1'b1;
        reset_sb(32'h100);
        step();
        i_pc_src_e = 1'b0; i_flush_d = 1'b0; ndeliv = 0;
        for (int i = 0; i < 20; i++) step();
        chk("redir_delivers", 64'(ndeliv >= 3), 64'd1);
        // memory not ready, then slow responses
        i_imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        i_imem_ready = 1'b1; ndeliv = 0;
        for (int i = 0; i < 16; i++) step();
        chk("slow_delivers", 64'(ndeliv >= 3), 64'd1);
        // reset with a full FIFO
        lat = 1;
        for (int i = 0; i < 4; i++) step();
        i_stall_d = 1'b1;
        step(); step(); step();
        chk("fifo_full", 64'(dut.cnt_q), 64'd2);
        i_rst = 1'b1; reset_sb(32'h0);
        step();
        i_rst = 1'b0; i_stall_d = 1'b0; ndeliv = 0;
        for (int i = 0; i < 8; i++) step();
        chk("restart_delivers", 64'(ndeliv), 64'd7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
